ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch initiator for the 5-stage MIPS pipeline: owns the F-stage PC, drives the word address into the combinational instruction memory and captures the returned word into the IF/ID register.
- Computes next PC from sequential, branch, J/JAL and JR redirect requests issued by D stage.
- Architectural branch delay slot: redirects never squash the instruction already in IF/ID.
- Sits between the hazard unit (stall) and D-stage decode/compare logic.

Parameters:
- RESET_PC, 32'h00003000, PC value loaded on reset.
- IM_BASE, 32'h00003000, byte address of instruction memory word 0.
- IM_WORDS, 4096, instruction memory depth in 32-bit words; legal fetch range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  from hazard unit; freezes PC_F and IF/ID.
- npc_sel  in  2  redirect kind: 0 sequential, 1 branch, 2 J/JAL, 3 JR/JALR.
- br_taken  in  1  branch compare result from D; meaningful only when npc_sel=1.
- br_imm  in  16  imm16 of the branch in D.
- j_index  in  26  instr_index of the J/JAL in D.
- jr_target  in  32  forwarded rs value for JR/JALR.
- im_addr  out  32  byte PC presented to instruction memory (= PC_F).
- im_instr  in  32  instruction word returned combinationally for im_addr.
- pc_f  out  32  current F-stage PC.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc8_d  out  32  pc_d+8, the JAL/JALR link value.
- fetch_fault  out  1  F-stage PC misaligned or out of range (combinational).
- fault_d  out  1  registered fetch_fault travelling with instr_d.

Behaviour:
- Reset (clk edge with reset=1): PC_F=RESET_PC, instr_d=0, pc_d=RESET_PC, fault_d=0. Reset overrides stall and all redirects. Reset mid-stall or mid-redirect discards the pending request.
- im_addr=pc_f=PC_F, combinational. Instruction is available the same cycle; IF/ID latency is 1 clock.
- fetch_fault=1 when PC_F[1:0]!=0, PC_F<IM_BASE, or PC_F>=IM_BASE+4*IM_WORDS. The comparison uses 33-bit arithmetic so the upper bound cannot wrap.
- Next PC (npc), all adds modulo 2^32:
  - npc_sel 0: PC_F+4.
  - npc_sel 1: if br_taken, pc_d+4+(sext(br_imm)<<2); otherwise PC_F+4.
  - npc_sel 2: {pc_d[31:28], j_index, 2'b00}.
  - npc_sel 3: jr_target, loaded unmodified. A misaligned target is not corrected; it is flagged by fetch_fault once it reaches F.
- Clock edge, reset=0, stall=0: PC_F<=npc; instr_d<=(fetch_fault ? 0 : im_instr); pc_d<=PC_F; fault_d<=fetch_fault. A faulting fetch therefore enters D as a nop (0x00000000).
- Clock edge, stall=1: PC_F, instr_d, pc_d and fault_d all hold. The redirect inputs are ignored that cycle; D stage re-presents them while the stall lasts.
- Delay slot: the instruction at branch_pc+4 is already in F when the branch is in D, and it is always captured into IF/ID. There is no flush.
- pc8_d=pc_d+8, combinational, wraps modulo 2^32.
- State is PC_F plus the IF/ID register. There is no FSM beyond the stall hold/advance.

Optional Feature:
- Macro IFU_PERF_COUNT_EN.
- Defined: adds outputs perf_fetch[31:0] and perf_stall[31:0], both reset to 0.
  - perf_fetch increments on each edge that advances IF/ID with fetch_fault=0.
  - perf_stall increments on each edge with stall=1 and reset=0.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then run 3 cycles with npc_sel=0: pc_f is 0x3000, 0x3004, 0x3008, 0x300C. After the 3rd edge, pc_d=0x3008 and instr_d equals the word at IM index 2.
- Branch in D with pc_d=0x3010, br_imm=16'hFFFC, br_taken=1, npc_sel=1: next pc_f=0x3004. The delay-slot word from 0x3014 is still latched into instr_d. Same case with br_taken=0: next pc_f=PC_F+4.
- J with pc_d=0x3020, j_index=26'h0000C10: next pc_f=0x00003040. With the same pc_d=0x3020, pc8_d=0x3028.
- stall held high for 2 cycles with npc_sel=3: pc_f, pc_d and instr_d are unchanged through both cycles. Redirect taken after release with jr_target=0x3100: pc_f becomes 0x3100.
- JR to 0x3102: fetch_fault=1, and the next edge gives instr_d=0, fault_d=1. JR to 0x7000 (IM_WORDS=4096, top of range 0x6FFC): fetch_fault=1.
- Assert reset during stall with a pending branch: pc_f=0x3000 and instr_d=0 after the edge. With IFU_PERF_COUNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: fetch-stage bus between D stage/hazard unit, instruction memory and ifu_fetch.
// Optional IFU_PERF_COUNT_EN adds the perf_fetch/perf_stall counter outputs.
interface ifu_fetch_if;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] br_imm;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        fetch_fault;
    logic        fault_d;
`ifdef IFU_PERF_COUNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    modport master(
        output stall, npc_sel, br_taken, br_imm, j_index, jr_target, im_instr,
        input  im_addr, pc_f, instr_d, pc_d, pc8_d, fetch_fault, fault_d, perf_fetch, perf_stall
    );
    modport slave(
        input  stall, npc_sel, br_taken, br_imm, j_index, jr_target, im_instr,
        output im_addr, pc_f, instr_d, pc_d, pc8_d, fetch_fault, fault_d, perf_fetch, perf_stall
    );
`else
    modport master(
        output stall, npc_sel, br_taken, br_imm, j_index, jr_target, im_instr,
        input  im_addr, pc_f, instr_d, pc_d, pc8_d, fetch_fault, fault_d
    );
    modport slave(
        input  stall, npc_sel, br_taken, br_imm, j_index, jr_target, im_instr,
        output im_addr, pc_f, instr_d, pc_d, pc8_d, fetch_fault, fault_d
    );
`endif
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: F-stage PC, next-PC selection and IF/ID register with architectural delay slot.
// Optional IFU_PERF_COUNT_EN adds saturating fetch/stall counters.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input logic        clk,
    input logic        reset,
    ifu_fetch_if.slave bus
);
    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic        r_fault_d;
    logic [32:0] w_lim;
    logic        w_fault;
    logic [31:0] w_seq;
    logic [31:0] w_br;
    logic [31:0] w_npc;

    // 33-bit upper bound so IM_BASE+4*IM_WORDS cannot wrap to a small value
    assign w_lim   = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);
    assign w_fault = (|r_pc_f[1:0]) || (r_pc_f < IM_BASE) || ({1'b0, r_pc_f} >= w_lim);
    assign w_seq   = r_pc_f + 32'd4;
    assign w_br    = r_pc_d + 32'd4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};

    always_comb begin
        w_npc = w_seq;
        case (bus.npc_sel)
            2'd1:    w_npc = bus.br_taken ? w_br : w_seq;
            2'd2:    w_npc = {r_pc_d[31:28], bus.j_index, 2'b00};
            2'd3:    w_npc = bus.jr_target;
            default: w_npc = w_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f    <= RESET_PC;
            r_instr_d <= '0;
            r_pc_d    <= RESET_PC;
            r_fault_d <= 1'b0;
        end else if (!bus.stall) begin
            r_pc_f    <= w_npc;
            r_instr_d <= w_fault ? 32'd0 : bus.im_instr;
            r_pc_d    <= r_pc_f;
            r_fault_d <= w_fault;
        end
    end

    assign bus.im_addr     = r_pc_f;
    assign bus.pc_f        = r_pc_f;
    assign bus.instr_d     = r_instr_d;
    assign bus.pc_d        = r_pc_d;
    assign bus.pc8_d       = r_pc_d + 32'd8;
    assign bus.fetch_fault = w_fault;
    assign bus.fault_d     = r_fault_d;

`ifdef IFU_PERF_COUNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (!bus.stall && !w_fault && r_perf_fetch != '1)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (bus.stall && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign bus.perf_fetch = r_perf_fetch;
    assign bus.perf_stall = r_perf_stall;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vectors with a cycle-tagged expectation queue checked by a separate monitor.
module tb_ifu_fetch;
    localparam int S_PC_F = 0, S_INSTR_D = 1, S_PC_D = 2, S_PC8_D = 3, S_FAULT = 4,
                   S_FAULT_D = 5, S_IM_ADDR = 6, S_PERF_F = 7, S_PERF_S = 8;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];

    ifu_fetch_if bus();

    ifu_fetch dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Instruction memory model: word tagged with its own address
    assign bus.im_instr = {16'hC0DE, bus.im_addr[15:0]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int sig);
        case (sig)
            S_PC_F:    return bus.pc_f;
            S_INSTR_D: return bus.instr_d;
            S_PC_D:    return bus.pc_d;
            S_PC8_D:   return bus.pc8_d;
            S_FAULT:   return {31'd0, bus.fetch_fault};
            S_FAULT_D: return {31'd0, bus.fault_d};
            S_IM_ADDR: return bus.im_addr;
`ifdef IFU_PERF_COUNT_EN
            S_PERF_F:  return bus.perf_fetch;
            S_PERF_S:  return bus.perf_stall;
`endif
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            n_vec++;
            a = actual(e.sig);
            if (e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
            end else if (a !== e.val) begin
                n_bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, a, e.val, cyc);
            end
        end
    end

    // d=0: check this cycle's combinational outputs; d=1: state after the next edge
    task automatic expect_at(input int d, input int sig, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + d;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.npc_sel = 2'd0;
        bus.br_taken = 1'b0;
        bus.br_imm = 16'd0;
        bus.j_index = 26'd0;
        bus.jr_target = 32'd0;
        tick();
        reset = 1'b0;
        expect_at(0, S_PC_F, 32'h3000, "reset_pc_f");
        expect_at(0, S_IM_ADDR, 32'h3000, "reset_im_addr");
        expect_at(0, S_INSTR_D, 32'h0, "reset_instr_d");
        expect_at(0, S_PC_D, 32'h3000, "reset_pc_d");
        expect_at(0, S_FAULT_D, 32'h0, "reset_fault_d");
        expect_at(0, S_FAULT, 32'h0, "reset_fetch_fault");
`ifdef IFU_PERF_COUNT_EN
        expect_at(0, S_PERF_F, 32'h0, "reset_perf_fetch");
        expect_at(0, S_PERF_S, 32'h0, "reset_perf_stall");
`endif
        // Sequential fetch
        expect_at(1, S_PC_F, 32'h3004, "seq1_pc_f");
        tick();
        expect_at(1, S_PC_F, 32'h3008, "seq2_pc_f");
        tick();
        expect_at(1, S_PC_F, 32'h300C, "seq3_pc_f");
        expect_at(1, S_PC_D, 32'h3008, "seq3_pc_d");
        expect_at(1, S_INSTR_D, 32'hC0DE3008, "seq3_instr_d");
        tick();
        tick();
        expect_at(1, S_PC_D, 32'h3010, "pre_br_pc_d");
        tick();
        // Taken branch in D at 0x3010, delay slot at 0x3014 still captured
        bus.npc_sel = 2'd1;
        bus.br_taken = 1'b1;
        bus.br_imm = 16'hFFFC;
        expect_at(1, S_PC_F, 32'h3004, "br_taken_pc_f");
        expect_at(1, S_INSTR_D, 32'hC0DE3014, "br_delay_slot_instr_d");
        expect_at(1, S_PC_D, 32'h3014, "br_delay_slot_pc_d");
        tick();
        bus.br_taken = 1'b0;
        expect_at(1, S_PC_F, 32'h3008, "br_not_taken_pc_f");
        tick();
        // J to 0x3020 to set up pc_d, then J with j_index 0xC10
        bus.npc_sel = 2'd2;
        bus.j_index = 26'h0000C08;
        expect_at(1, S_PC_F, 32'h3020, "j_setup_pc_f");
        tick();
        bus.npc_sel = 2'd0;
        expect_at(1, S_PC_D, 32'h3020, "j_pc_d");
        expect_at(1, S_PC8_D, 32'h3028, "j_pc8_d");
        tick();
        bus.npc_sel = 2'd2;
        bus.j_index = 26'h0000C10;
        expect_at(1, S_PC_F, 32'h3040, "j_pc_f");
        tick();
        // Stall for 2 cycles with a pending JR
        bus.npc_sel = 2'd0;
        expect_at(1, S_PC_D, 32'h3040, "pre_stall_pc_d");
        tick();
        bus.stall = 1'b1;
        bus.npc_sel = 2'd3;
        bus.jr_target = 32'h3100;
        for (int i = 1; i <= 2; i++) begin
            expect_at(i, S_PC_F, 32'h3044, "stall_pc_f");
            expect_at(i, S_PC_D, 32'h3040, "stall_pc_d");
            expect_at(i, S_INSTR_D, 32'hC0DE3040, "stall_instr_d");
        end
        tick();
        tick();
        bus.stall = 1'b0;
        expect_at(1, S_PC_F, 32'h3100, "jr_after_stall_pc_f");
        expect_at(1, S_PC_D, 32'h3044, "jr_after_stall_pc_d");
`ifdef IFU_PERF_COUNT_EN
        expect_at(1, S_PERF_S, 32'd2, "perf_stall_count");
`endif
        tick();
        // Fault cases: misaligned, top-of-range boundary, past range, below base
        bus.jr_target = 32'h3102;
        tick();
        expect_at(0, S_FAULT, 32'h1, "misaligned_fetch_fault");
        bus.npc_sel = 2'd0;
        expect_at(1, S_INSTR_D, 32'h0, "fault_instr_d_nop");
        expect_at(1, S_FAULT_D, 32'h1, "fault_d");
        expect_at(1, S_PC_D, 32'h3102, "fault_pc_d");
        tick();
        bus.npc_sel = 2'd3;
        bus.jr_target = 32'h6FFC;
        tick();
        expect_at(0, S_FAULT, 32'h0, "top_word_no_fault");
        bus.jr_target = 32'h7000;
        tick();
        expect_at(0, S_FAULT, 32'h1, "past_top_fault");
        bus.jr_target = 32'h2FFC;
        tick();
        expect_at(0, S_FAULT, 32'h1, "below_base_fault");
        // Reset during a stall with a pending taken branch
        bus.stall = 1'b1;
        bus.npc_sel = 2'd1;
        bus.br_taken = 1'b1;
        reset = 1'b1;
        expect_at(1, S_PC_F, 32'h3000, "reset_in_stall_pc_f");
        expect_at(1, S_INSTR_D, 32'h0, "reset_in_stall_instr_d");
        expect_at(1, S_PC_D, 32'h3000, "reset_in_stall_pc_d");
        expect_at(1, S_FAULT_D, 32'h0, "reset_in_stall_fault_d");
`ifdef IFU_PERF_COUNT_EN
        expect_at(1, S_PERF_F, 32'h0, "reset_in_stall_perf_fetch");
        expect_at(1, S_PERF_S, 32'h0, "reset_in_stall_perf_stall");
`endif
        tick();
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.npc_sel = 2'd0;
        for (int i = 0; i < 5 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
